// File: rtl/gppcu_pkg.sv
// Shared GPPCU datapath types: default result widths and the writeback result record.
package gppcu_pkg;

    localparam int WB_REG_W  = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_REG_W-1:0]  idx;
        logic [WB_DATA_W-1:0] data;
    } wb_result_t;

endpackage

// File: rtl/gppcu_wb_fifo.sv
// Small synchronous FIFO holding LSU results until an ALU idle slot frees the write port.
module gppcu_wb_fifo import gppcu_pkg::*; #(
    parameter int W     = WB_REG_W + WB_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer width equals log2(DEPTH), so natural overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/gppcu_wb_arbiter.sv
// Writeback arbiter: ALU results always win the register-file port; LSU results queue
// in a FIFO and drain in ALU idle slots, with a starvation hold to force draining.
module gppcu_wb_arbiter import gppcu_pkg::*; #(
    parameter int REG_W        = WB_REG_W,
    parameter int DATA_W       = WB_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        iACLK,
    input  logic                        iRST,
    input  logic                        iALU_VALID,
    input  logic [REG_W-1:0]            iALU_REG,
    input  logic [DATA_W-1:0]           iALU_DATA,
    input  logic                        iLSU_VALID,
    output logic                        oLSU_READY,
    input  logic [REG_W-1:0]            iLSU_REG,
    input  logic [DATA_W-1:0]           iLSU_DATA,
    output logic                        oWR_EN,
    output logic [REG_W-1:0]            oWR_REG,
    output logic [DATA_W-1:0]           oWR_DATA,
    output logic                        oISSUE_HOLD,
    output logic [$clog2(FIFO_DEPTH):0] oFIFO_COUNT
);
    localparam int W  = REG_W + DATA_W;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [W-1:0]      fifo_head;
    logic              lsu_xfer;

    logic              wr_en_q,   wr_en_d;
    logic [REG_W-1:0]  wr_reg_q,  wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [SW-1:0]     starve_q,  starve_d;
    logic              hold_q,    hold_d;

    gppcu_wb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (iACLK),
        .rst   (iRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({iLSU_REG, iLSU_DATA}),
        .head  (fifo_head),
        .count (oFIFO_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready looks only at the registered count; a same-cycle pop does not open a slot.
    assign oLSU_READY = ~fifo_full;
    assign lsu_xfer   = iLSU_VALID & ~fifo_full;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (iALU_VALID) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = iALU_REG;
            wr_data_d = iALU_DATA;
            fifo_push = lsu_xfer;
        end else if (!fifo_empty) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = fifo_head[W-1:DATA_W];
            wr_data_d = fifo_head[DATA_W-1:0];
            fifo_pop  = 1'b1;
            fifo_push = lsu_xfer;
        end else if (lsu_xfer) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = iLSU_REG;
            wr_data_d = iLSU_DATA;
        end

        starve_d = starve_q;
        if (fifo_empty || fifo_pop)
            starve_d = '0;
        else if (iALU_VALID && starve_q != LIMIT)
            starve_d = starve_q + SW'(1);
        hold_d = (starve_d == LIMIT);
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            starve_q  <= '0;
            hold_q    <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            starve_q  <= starve_d;
            hold_q    <= hold_d;
        end
    end

    assign oWR_EN      = wr_en_q;
    assign oWR_REG     = wr_reg_q;
    assign oWR_DATA    = wr_data_q;
    assign oISSUE_HOLD = hold_q;

endmodule

// File: tb/tb_gppcu_wb_arbiter.sv
// Bench for gppcu_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_gppcu_wb_arbiter;
    import gppcu_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_v, lsu_v, lsu_rdy, wr_en, hold;
    logic [4:0]  alu_r, lsu_r, wr_r;
    logic [31:0] alu_d, lsu_d, wr_d;
    logic [2:0]  fcnt;

    always #5 clk = ~clk;

    gppcu_wb_arbiter #(.REG_W(5), .DATA_W(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .iACLK(clk), .iRST(rst),
        .iALU_VALID(alu_v), .iALU_REG(alu_r), .iALU_DATA(alu_d),
        .iLSU_VALID(lsu_v), .oLSU_READY(lsu_rdy), .iLSU_REG(lsu_r), .iLSU_DATA(lsu_d),
        .oWR_EN(wr_en), .oWR_REG(wr_r), .oWR_DATA(wr_d),
        .oISSUE_HOLD(hold), .oFIFO_COUNT(fcnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending LSU results in arrival order, plus the last write seen.
    wb_result_t  mq[$];
    int          m_starve = 0;
    bit          m_hold = 1'b0, m_en = 1'b0, m_init = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ld, output bit acc);
        bit         rdy, xfer, was_empty, popped;
        wb_result_t item;
        @(negedge clk);
        rst = r; alu_v = av; alu_r = ar; alu_d = ad; lsu_v = lv; lsu_r = lr; lsu_d = ld;
        #1;
        rdy = (mq.size() != DEPTH);
        if (m_init) chk("lsu_ready", lsu_rdy, rdy);
        @(posedge clk);
        xfer = m_init && !r && lv && rdy;
        acc  = xfer;
        if (r) begin
            mq.delete();
            m_starve = 0; m_hold = 0; m_en = 0; m_reg = '0; m_data = '0; m_init = 1;
        end else if (m_init) begin
            was_empty = (mq.size() == 0);
            popped = 0;
            item.idx = lr; item.data = ld;
            if (av) begin
                m_en = 1; m_reg = ar; m_data = ad;
                if (xfer) mq.push_back(item);
            end else if (!was_empty) begin
                wb_result_t h;
                h = mq.pop_front();
                popped = 1;
                m_en = 1; m_reg = h.idx; m_data = h.data;
                if (xfer) mq.push_back(item);
            end else if (xfer) begin
                m_en = 1; m_reg = lr; m_data = ld;
            end else begin
                m_en = 0;
            end
            if (was_empty || popped) m_starve = 0;
            else if (av && m_starve < LIMIT) m_starve++;
            m_hold = (m_starve == LIMIT);
        end
        #1;
        if (m_init) begin
            chk("wr_en", wr_en, m_en);
            chk("wr_reg", wr_r, m_reg);
            chk("wr_data", wr_d, m_data);
            chk("fifo_count", fcnt, mq.size());
            chk("issue_hold", hold, m_hold);
        end
    endtask

    initial begin
        bit acc;
        int idx;
        bit pend;
        logic [4:0]  pr;
        logic [31:0] pd;
        rst = 1; alu_v = 0; alu_r = 0; alu_d = 0; lsu_v = 0; lsu_r = 0; lsu_d = 0;

        // Reset held two cycles with ALU traffic present
        step(1, 1, 5'd1, 32'h1, 0, 0, 0, acc);
        step(1, 1, 5'd2, 32'h2, 0, 0, 0, acc);
        chk("rst_en", wr_en, 0);
        chk("rst_cnt", fcnt, 0);
        chk("rst_hold", hold, 0);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("rst_ready", lsu_rdy, 1);

        // Bypass
        step(0, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF, acc);
        chk("byp_en", wr_en, 1);
        chk("byp_reg", wr_r, 7);
        chk("byp_data", wr_d, 32'hDEADBEEF);
        chk("byp_cnt", fcnt, 0);

        // ALU/LSU conflict
        step(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'h22, acc);
        chk("cfl_reg1", wr_r, 3);
        chk("cfl_data1", wr_d, 32'h11);
        chk("cfl_cnt1", fcnt, 1);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("cfl_reg2", wr_r, 9);
        chk("cfl_data2", wr_d, 32'h22);
        chk("cfl_cnt2", fcnt, 0);

        // Full and backpressure: six LSU results against continuous ALU traffic
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(0, 1, 5'd1, 32'h100 + c, idx < 6, 5'(10 + idx), 32'hA0 + idx, acc);
            if (acc) idx++;
        end
        chk("full_accepted", idx, 4);
        chk("full_cnt", fcnt, 4);
        chk("full_ready", lsu_rdy, 0);
        for (int c = 0; c < 20 && (idx < 6 || mq.size() != 0); c++) begin
            step(0, 0, 0, 0, idx < 6, 5'(10 + idx), 32'hA0 + idx, acc);
            if (acc) idx++;
        end
        chk("drain_accepted", idx, 6);
        chk("drain_cnt", fcnt, 0);
        chk("drain_last_reg", wr_r, 15);

        // Starvation: one queued entry, ALU busy
        step(0, 1, 5'd2, 32'h5, 1, 5'd4, 32'h44, acc);
        for (int c = 0; c < 7; c++) step(0, 1, 5'd2, 32'h6 + c, 0, 0, 0, acc);
        chk("starve_hold7", hold, 0);
        step(0, 1, 5'd2, 32'h20, 0, 0, 0, acc);
        chk("starve_hold8", hold, 1);
        step(0, 1, 5'd2, 32'h21, 0, 0, 0, acc);
        chk("starve_hold9", hold, 1);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("starve_pop_reg", wr_r, 4);
        chk("starve_pop_data", wr_d, 32'h44);
        chk("starve_release", hold, 0);

        // Mid-operation reset with three queued results
        for (int c = 0; c < 3; c++) step(0, 1, 5'd1, 32'h7, 1, 5'(20 + c), 32'hC0 + c, acc);
        chk("mid_cnt3", fcnt, 3);
        step(1, 0, 0, 0, 0, 0, 0, acc);
        chk("mid_rst_cnt", fcnt, 0);
        chk("mid_rst_en", wr_en, 0);
        for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("mid_no_write", wr_en, 0);

        // Random traffic; the LSU keeps its offer stable until accepted
        pend = 0; pr = 0; pd = 0;
        for (int c = 0; c < 800; c++) begin
            if (!pend && $urandom_range(0, 99) < 50) begin
                pend = 1; pr = 5'($urandom); pd = $urandom;
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 60,
                 5'($urandom), $urandom, pend, pr, pd, acc);
            if (acc || rst) pend = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
